// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-ROM port scheduler: burst FSM encoding and ROM constants.
package imem_pkg;
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_RUN   = 2'd1,
        D_DRAIN = 2'd2,
        D_DONE  = 2'd3
    } dbg_state_e;

    localparam int unsigned WORD_BYTES     = 4;
    localparam logic [31:0] ROM_FAULT_WORD = 32'h8000_0000;
endpackage

// File: rtl/imem_dbg_burst.sv
// Debug burst engine: walks a word-aligned ROM region, one word per grant, then signals completion.
module imem_dbg_burst
    import imem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              gnt_i,
    output logic              pend_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    dbg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic              zdone_q, zdone_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        zdone_d = 1'b0;
        case (state_q)
            D_IDLE: begin
                if (start_i) begin
                    if (base_i[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (count_i == '0) begin
                            zdone_d = 1'b1;
                        end else begin
                            ptr_d   = base_i;
                            rem_d   = count_i;
                            state_d = D_RUN;
                        end
                    end
                end
            end
            D_RUN: begin
                if (gnt_i) begin
                    ptr_d = ptr_q + ADDR_W'(WORD_BYTES);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = D_DRAIN;
                end
            end
            D_DRAIN: state_d = D_DONE;
            D_DONE:  state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
        // A start seen in any busy state, D_DONE included, is rejected.
        if (start_i && state_q != D_IDLE) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= D_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            zdone_q <= zdone_d;
        end
    end

    assign pend_o = (state_q == D_RUN);
    assign addr_o = ptr_q;
    assign busy_o = (state_q != D_IDLE);
    assign done_o = (state_q == D_DONE) | zdone_q;
    assign err_o  = err_q;
endmodule

// File: rtl/imem_port_scheduler.sv
// Arbitrates the single ROM read port between IF (priority) and the debug burst engine,
// with a starvation counter forcing debug a slot; read data is registered per requester.
module imem_port_scheduler
    import imem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_stall_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dbg_start_i,
    input  logic [ADDR_W-1:0] dbg_base_i,
    input  logic [CNT_W-1:0]  dbg_count_i,
    output logic              dbg_busy_o,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_rdata_o,
    output logic              dbg_done_o,
    output logic              dbg_err_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i
);
    logic              dbg_pend, dbg_win;
    logic [ADDR_W-1:0] dbg_addr;
    logic [7:0]        starve_q, starve_d;
    logic              if_rvalid_q, dbg_rvalid_q;
    logic [31:0]       if_rdata_q, dbg_rdata_q;

    imem_dbg_burst #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_burst (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (dbg_start_i),
        .base_i  (dbg_base_i),
        .count_i (dbg_count_i),
        .gnt_i   (dbg_win),
        .pend_o  (dbg_pend),
        .addr_o  (dbg_addr),
        .busy_o  (dbg_busy_o),
        .done_o  (dbg_done_o),
        .err_o   (dbg_err_o)
    );

    assign dbg_win    = dbg_pend & (~if_req_i | (starve_q == 8'(STARVE_LIMIT)));
    assign if_gnt_o   = if_req_i & ~dbg_win;
    assign if_stall_o = if_req_i & ~if_gnt_o;
    assign rom_addr_o = dbg_win ? dbg_addr : if_addr_i;

    always_comb begin
        starve_d = '0;
        if (dbg_pend && !dbg_win)
            starve_d = (starve_q == 8'(STARVE_LIMIT)) ? starve_q : starve_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q     <= '0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            if_rvalid_q  <= if_gnt_o;
            dbg_rvalid_q <= dbg_win;
            if (if_gnt_o) if_rdata_q  <= rom_data_i;
            if (dbg_win)  dbg_rdata_q <= rom_data_i;
        end
    end

    assign if_rvalid_o  = if_rvalid_q;
    assign if_rdata_o   = if_rdata_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign dbg_rdata_o  = dbg_rdata_q;
endmodule

// File: tb/tb_imem_port_scheduler.sv
// Randomized and directed bench for imem_port_scheduler against a cycle-level behavioural model.
module tb_imem_port_scheduler;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, dbg_start;
    logic [AW-1:0] if_addr, dbg_base, rom_addr;
    logic [CW-1:0] dbg_count;
    logic          if_gnt, if_stall, if_rvalid, dbg_busy, dbg_rvalid, dbg_done, dbg_err;
    logic [31:0]   if_rdata, dbg_rdata, rom_data;

    int nchk = 0;
    int nerr = 0;

    imem_port_scheduler #(.ADDR_W(AW), .CNT_W(CW), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_stall_o(if_stall),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dbg_start_i(dbg_start), .dbg_base_i(dbg_base), .dbg_count_i(dbg_count),
        .dbg_busy_o(dbg_busy), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .dbg_done_o(dbg_done), .dbg_err_o(dbg_err),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data)
    );

    always #5 clk = ~clk;
    assign rom_data = 32'hA500_0000 + (rom_addr >> 2);

    // Model: words left to read, drain/done countdown, wait cycles, zero-count done pulse.
    int          m_left, m_tail, m_wait;
    logic [31:0] m_ptr, m_ifd, m_dbgd;
    logic        m_err, m_zdone, m_ifv, m_dbgv;
    logic        m_pend, m_win, m_ignt;
    logic [31:0] m_raddr;
    logic [31:0] pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_tail = 0; m_wait = 0; m_ptr = 0;
        m_ifd = 0; m_dbgd = 0; m_err = 0; m_zdone = 0; m_ifv = 0; m_dbgv = 0;
    endtask

    // Entered at posedge+1; drives inputs, checks before the next edge, updates model at the edge.
    task automatic cyc(input logic rq, input logic [31:0] a, input logic st,
                       input logic [31:0] b, input logic [15:0] c);
        logic busy, zd;
        if_req = rq; if_addr = a; dbg_start = st; dbg_base = b; dbg_count = c;
        #2;
        m_pend  = (m_left > 0);
        m_win   = m_pend && (!rq || m_wait == SL);
        m_ignt  = rq && !m_win;
        m_raddr = m_win ? m_ptr : a;
        busy    = (m_left > 0) || (m_tail > 0);
        chk("if_gnt", 32'(if_gnt), 32'(m_ignt));
        chk("if_stall", 32'(if_stall), 32'(rq && !m_ignt));
        chk("rom_addr", rom_addr, m_raddr);
        chk("if_rvalid", 32'(if_rvalid), 32'(m_ifv));
        chk("if_rdata", if_rdata, m_ifd);
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_dbgv));
        chk("dbg_rdata", dbg_rdata, m_dbgd);
        chk("dbg_done", 32'(dbg_done), 32'(m_tail == 1 || m_zdone));
        chk("dbg_busy", 32'(dbg_busy), 32'(busy));
        chk("dbg_err", 32'(dbg_err), 32'(m_err));
        @(posedge clk);
        m_ifv = m_ignt;
        if (m_ignt) m_ifd = 32'hA500_0000 + (a >> 2);
        m_dbgv = m_win;
        if (m_win) m_dbgd = 32'hA500_0000 + (m_ptr >> 2);
        zd = 1'b0;
        if (m_tail > 0) m_tail--;
        if (m_win) begin
            m_ptr += 4;
            m_left--;
            if (m_left == 0) m_tail = 2;
        end
        m_wait = (m_pend && !m_win) ? ((m_wait < SL) ? m_wait + 1 : SL) : 0;
        if (st) begin
            if (busy || b[1:0] != 2'b00) m_err = 1'b1;
            else begin
                m_err = 1'b0;
                if (c == 0) zd = 1'b1;
                else begin m_left = int'(c); m_ptr = b; end
            end
        end
        m_zdone = zd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 16'h0);
    endtask

    // IF stage that only advances its PC on a predicted grant.
    task automatic fetch(input int n, input int pct);
        logic rq;
        for (int i = 0; i < n; i++) begin
            rq = ($urandom_range(99) < pct);
            cyc(rq, pc, 1'b0, 32'h0, 16'h0);
            if (m_ignt) pc = (pc + 4) & 32'hFF;
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = 0; dbg_start = 0; dbg_base = 0; dbg_count = 0;
        model_reset();
        #3;
        chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("rst_dbg_busy", 32'(dbg_busy), 32'h0);
        chk("rst_dbg_done", 32'(dbg_done), 32'h0);
        chk("rst_dbg_err", 32'(dbg_err), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // IF back-to-back
        cyc(1, 32'h0, 0, 0, 0); cyc(1, 32'h4, 0, 0, 0); cyc(1, 32'h8, 0, 0, 0);
        idle(2);
        // debug only
        cyc(0, 0, 1, 32'h10, 16'd3);
        idle(7);
        // starvation with IF saturating the port
        pc = 0;
        cyc(1, pc, 1, 32'h0, 16'd2);
        if (m_ignt) pc = pc + 4;
        fetch(30, 100);
        idle(2);
        // misaligned start, then an aligned one clears the error
        cyc(0, 0, 1, 32'h6, 16'd3);
        idle(3);
        cyc(0, 0, 1, 32'h20, 16'd2);
        idle(6);
        // start while busy, then zero-length burst
        cyc(0, 0, 1, 32'h40, 16'd4);
        cyc(0, 0, 1, 32'h0, 16'd1);
        idle(8);
        cyc(0, 0, 1, 32'h80, 16'd0);
        idle(3);
        // start landing exactly in D_DONE
        cyc(0, 0, 1, 32'h30, 16'd1);
        idle(2);
        cyc(0, 0, 1, 32'h50, 16'd2);
        idle(6);
        // asynchronous reset mid-burst
        cyc(0, 0, 1, 32'h100, 16'd5);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dbg_busy", 32'(dbg_busy), 32'h0);
        chk("arst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("arst_dbg_rdata", dbg_rdata, 32'h0);
        chk("arst_dbg_done", 32'(dbg_done), 32'h0);
        chk("arst_dbg_err", 32'(dbg_err), 32'h0);
        chk("arst_if_rvalid", 32'(if_rvalid), 32'h0);
        model_reset();
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 32'h0, 0, 0, 0);
        idle(4);

        // random traffic
        pc = 0;
        for (int k = 0; k < 500; k++) begin
            logic        rq, st;
            logic [31:0] b;
            rq = ($urandom_range(99) < 75);
            st = ($urandom_range(99) < 6);
            b  = {22'h0, 8'($urandom_range(255)), 2'b00};
            if ($urandom_range(9) == 0) b[1:0] = 2'($urandom_range(3));
            cyc(rq, pc, st, b, 16'($urandom_range(5)));
            if (m_ignt) pc = (pc + 4) & 32'hFF;
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
